// File: rtl/serial_word_receiver_pkg.sv
// Shared definitions for the serial word receiver.
//   - Receiver FSM state encoding
//   - Framing bit levels (start bit and stop bit)
package serial_word_receiver_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] DATA = 2'b01;
  localparam logic [1:0] STOP = 2'b10;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StData = DATA,
    StStop = STOP
  } rx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_word_shifter.sv
// WIDTH-bit serial-in / parallel-out shift register.
// Each new bit enters at bit 0 and older bits move toward the MSB. After WIDTH shifts,
// the first bit received is therefore in data_o[WIDTH-1].
// Ports:
//   clk_i      rising-edge clock
//   clear_i    synchronous active-high clear (register goes to 0)
//   shift_en_i shift bit_i in this cycle
//   bit_i      serial input bit
//   data_o     current register contents
module serial_word_shifter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             shift_en_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (shift_en_i) begin
      data_d = {data_q[WIDTH-2:0], bit_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/serial_word_receiver.sv
// Framed serial-to-parallel receiver. Each frame has a start bit (0), then WIDTH data bits
// sent MSB first, then a stop bit (1). The line is sampled only on bit_en strobes.
// Ports:
//   clk          rising-edge clock
//   clear        synchronous active-high reset
//   bit_en       one-cycle bit strobe; serial_in is sampled only when this is set
//   serial_in    serial line, idles high
//   data_ready   consumer accepts parallel_out when data_valid is also set
//   parallel_out last good word received
//   data_valid   parallel_out holds a word that has not yet been accepted
//   frame_error  one-cycle pulse when the stop bit is sampled as 0
//   overrun      one-cycle pulse when a new word replaces one that was never accepted
//   busy         receiver is inside a frame
module serial_word_receiver
  import serial_word_receiver_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             bit_en,
  input  logic             serial_in,
  input  logic             data_ready,
  output logic [WIDTH-1:0] parallel_out,
  output logic             data_valid,
  output logic             frame_error,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  rx_state_e        state_d, state_q;
  logic [CntW-1:0]  cnt_d, cnt_q;
  logic [WIDTH-1:0] pout_d, pout_q;
  logic             valid_d, valid_q;
  logic             ferr_d, ferr_q;
  logic             ovr_d, ovr_q;
  logic             shift_en;
  logic [WIDTH-1:0] shift_data;

  serial_word_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk_i      (clk),
    .clear_i    (clear),
    .shift_en_i (shift_en),
    .bit_i      (serial_in),
    .data_o     (shift_data)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pout_d   = pout_q;
    valid_d  = valid_q;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;
    shift_en = 1'b0;

    // Handshake is independent of bit_en. A load in the same cycle overrides it below.
    if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (bit_en && (serial_in == START_BIT)) begin
          state_d = StData;
          cnt_d   = '0;
        end
      end
      StData: begin
        if (bit_en) begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (bit_en) begin
          state_d = StIdle;
          if (serial_in == STOP_BIT) begin
            pout_d  = shift_data;
            valid_d = 1'b1;
            // If the old word is being accepted this cycle, replacing it is not an overrun.
            ovr_d   = valid_q && !data_ready;
          end else begin
            ferr_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pout_q  <= pout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign parallel_out = pout_q;
  assign data_valid   = valid_q;
  assign frame_error  = ferr_q;
  assign overrun      = ovr_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed testbench for serial_word_receiver (WIDTH=4). Expected values are hand-computed.
module tb_serial_word_receiver;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             clear;
  logic             bit_en;
  logic             serial_in;
  logic             data_ready;
  logic [WIDTH-1:0] parallel_out;
  logic             data_valid;
  logic             frame_error;
  logic             overrun;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  serial_word_receiver #(
    .WIDTH (WIDTH)
  ) dut (
    .clk          (clk),
    .clear        (clear),
    .bit_en       (bit_en),
    .serial_in    (serial_in),
    .data_ready   (data_ready),
    .parallel_out (parallel_out),
    .data_valid   (data_valid),
    .frame_error  (frame_error),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one bit with bit_en for one cycle, then idle for gap cycles.
  task automatic send_bit(input logic b, input int gap);
    bit_en    = 1'b1;
    serial_in = b;
    tick();
    bit_en    = 1'b0;
    serial_in = 1'b1;
    repeat (gap) tick();
  endtask

  // Sends WIDTH data bits, MSB first. The start and stop bits are sent separately.
  task automatic send_data(input logic [WIDTH-1:0] d, input int gap);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      send_bit(d[i], gap);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear      = 1'b1;
    bit_en     = 1'b0;
    serial_in  = 1'b1;
    data_ready = 1'b0;
    tick();
    tick();
    check("rst_pout", 32'(parallel_out), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_ferr", 32'(frame_error), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    clear = 1'b0;

    // Idle line with strobes: nothing happens.
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_valid", 32'(data_valid), 32'h0);

    // Good frame 1011
    send_bit(1'b0, 0);
    check("good_busy_start", 32'(busy), 32'h1);
    send_data(4'b1011, 0);
    check("good_valid_pre", 32'(data_valid), 32'h0);
    check("good_busy_stop", 32'(busy), 32'h1);
    send_bit(1'b1, 0);
    check("good_pout", 32'(parallel_out), 32'hb);
    check("good_valid", 32'(data_valid), 32'h1);
    check("good_busy_done", 32'(busy), 32'h0);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("good_accept", 32'(data_valid), 32'h0);
    check("good_pout_hold", 32'(parallel_out), 32'hb);

    // Bad stop bit: data 1100, stop 0
    send_bit(1'b0, 0);
    send_data(4'b1100, 0);
    send_bit(1'b0, 0);
    check("ferr_pulse", 32'(frame_error), 32'h1);
    check("ferr_pout", 32'(parallel_out), 32'hb);
    check("ferr_valid", 32'(data_valid), 32'h0);
    check("ferr_busy", 32'(busy), 32'h0);
    // Start the next frame right away. This also begins the overrun test (data 1111).
    send_bit(1'b0, 0);
    check("ferr_clear", 32'(frame_error), 32'h0);
    check("rearm_busy", 32'(busy), 32'h1);
    send_data(4'b1111, 0);
    send_bit(1'b1, 0);
    check("ovr1_pout", 32'(parallel_out), 32'hf);
    check("ovr1_valid", 32'(data_valid), 32'h1);
    check("ovr1_none", 32'(overrun), 32'h0);
    send_bit(1'b0, 0);
    send_data(4'b0010, 0);
    send_bit(1'b1, 0);
    check("ovr2_pout", 32'(parallel_out), 32'h2);
    check("ovr2_valid", 32'(data_valid), 32'h1);
    check("ovr2_pulse", 32'(overrun), 32'h1);
    check("ovr2_noferr", 32'(frame_error), 32'h0);
    tick();
    check("ovr2_clear", 32'(overrun), 32'h0);
    check("ovr2_hold", 32'(parallel_out), 32'h2);

    // Overrun again, then a load while the old word is accepted (no overrun).
    send_bit(1'b0, 0);
    send_data(4'b1111, 0);
    send_bit(1'b1, 0);
    check("ovr3_pulse", 32'(overrun), 32'h1);
    check("ovr3_pout", 32'(parallel_out), 32'hf);
    send_bit(1'b0, 0);
    send_data(4'b0010, 0);
    data_ready = 1'b1;
    send_bit(1'b1, 0);
    data_ready = 1'b0;
    check("acc_load_pout", 32'(parallel_out), 32'h2);
    check("acc_load_valid", 32'(data_valid), 32'h1);
    check("acc_load_novr", 32'(overrun), 32'h0);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("acc_final", 32'(data_valid), 32'h0);

    // Sparse strobes: a bit every 3rd cycle, data 0110
    send_bit(1'b0, 2);
    check("sparse_busy_start", 32'(busy), 32'h1);
    send_data(4'b0110, 2);
    check("sparse_busy_mid", 32'(busy), 32'h1);
    check("sparse_valid_pre", 32'(data_valid), 32'h0);
    send_bit(1'b1, 0);
    check("sparse_pout", 32'(parallel_out), 32'h6);
    check("sparse_valid", 32'(data_valid), 32'h1);
    check("sparse_busy_end", 32'(busy), 32'h0);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;

    // Clear after two data bits, then send a clean frame with data 1001.
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    check("midrst_busy_pre", 32'(busy), 32'h1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_ferr", 32'(frame_error), 32'h0);
    check("midrst_pout", 32'(parallel_out), 32'h0);
    tick();
    check("midrst_ferr2", 32'(frame_error), 32'h0);
    send_bit(1'b0, 0);
    send_data(4'b1001, 0);
    send_bit(1'b1, 0);
    check("post_rst_pout", 32'(parallel_out), 32'h9);
    check("post_rst_valid", 32'(data_valid), 32'h1);
    check("post_rst_ferr", 32'(frame_error), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Serial-to-parallel receiver: the receiving end of the framed bit stream produced by the team's universal shift register when it runs in right-shift mode.
- Receives one start bit (0), then WIDTH data bits MSB first, then one stop bit (1).
- Delivers each good word on a parallel output register under a valid/ready handshake.
- Sits between the serial link and the consuming datapath; bit timing comes from an external one-cycle bit_en strobe.

Parameters:
- WIDTH, 4, data bits per frame; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- clear  input  1  synchronous, active-high reset
- bit_en  input  1  one-cycle strobe; serial_in is sampled only on cycles where bit_en=1
- serial_in  input  1  serial line (idle level 1)
- data_ready  input  1  consumer accepts parallel_out in any cycle where data_valid=1 and data_ready=1
- parallel_out  output  WIDTH  last good received word; first received bit lands in parallel_out[WIDTH-1]
- data_valid  output  1  parallel_out holds an unaccepted word
- frame_error  output  1  one-cycle pulse: stop bit sampled as 0
- overrun  output  1  one-cycle pulse: a new word overwrote an unaccepted word
- busy  output  1  FSM is not in IDLE

Behaviour:
- Reset: clear=1 at a rising edge forces the following, regardless of state or other inputs:
  - state=IDLE, bit counter=0, shift register=0
  - parallel_out=0, data_valid=0, frame_error=0, overrun=0, busy=0
  - A reset mid-frame abandons that frame with no error pulse.
- All state changes happen only on cycles where bit_en=1, except the handshake and pulse clearing.
- FSM states: IDLE, DATA, STOP.
  - IDLE: if bit_en and serial_in=0 -> DATA, counter=0. If bit_en and serial_in=1, stay in IDLE.
  - DATA: on bit_en, shift_reg <= {shift_reg[WIDTH-2:0], serial_in} and counter increments. When counter=WIDTH-1 at that bit_en -> STOP. Exactly WIDTH data samples are taken.
  - STOP, bit_en and serial_in=1 (good word):
    - parallel_out <= shift_reg; data_valid <= 1
    - If data_valid was 1 and data_ready=0 in the same cycle, overrun pulses for one cycle; the new word replaces the old one.
    - Then -> IDLE.
  - STOP, bit_en and serial_in=0: frame_error pulses for one cycle; shift_reg is discarded; parallel_out and data_valid are unchanged; -> IDLE.
    - Re-arm is immediate: the next bit_en with serial_in=0 in IDLE starts a new frame.
- Latency: parallel_out and data_valid update on the clock edge that samples the stop bit, so they are visible the cycle after the stop-bit bit_en.
- Handshake:
  - data_valid and data_ready in the same cycle -> data_valid=0 next cycle.
  - Exception: if a good word is also loaded that cycle, data_valid stays 1 and there is no overrun (the old word counts as accepted).
  - parallel_out is stable while data_valid=1 and no new word is loaded.
  - data_ready is ignored while data_valid=0.
- frame_error and overrun are registered and self-clearing. They never assert in the same cycle.
- busy=1 in DATA and STOP.
- Back-to-back frames need no idle bits between them.
- bit_en gaps of any length are tolerated mid-frame.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'b00, DATA=2'b01, STOP=2'b10
  - START_BIT=1'b0, STOP_BIT=1'b1
- One natural sub-module: serial_word_shifter. It is a WIDTH-bit serial-in/parallel-out register with shift enable and synchronous clear.
- The top level contains the FSM, counter, output register and handshake logic.

Test Plan:
- Reset, WIDTH=4: hold clear for 2 cycles -> all outputs 0, busy=0. Then feed serial_in=1 with bit_en each cycle for 5 cycles -> no state change.
- Good frame, bit_en every cycle: serial bits 0,1,0,1,1,1 (start, data 1011, stop) -> one cycle after the stop sample, parallel_out=4'b1011 and data_valid=1. Hold data_ready=1 for 1 cycle -> data_valid=0.
- Bad stop bit: serial bits 0,1,1,0,0,0 -> frame_error pulses exactly 1 cycle. parallel_out keeps its previous value 4'b1011 and data_valid is unchanged. The next start bit is accepted immediately.
- Overrun: data_ready=0; send 0,1,1,1,1,1 (1111) then 0,0,0,1,0,1 (0010) -> second stop sample gives parallel_out=4'b0010, data_valid=1 and a one-cycle overrun pulse. Repeat with data_ready=1 on the second stop cycle -> no overrun.
- Sparse bit_en: bit_en every 3rd cycle with frame 0,0,1,1,0,1 -> parallel_out=4'b0110. busy=1 from the start sample until the stop sample.
- Reset mid-frame: assert clear after 2 data bits -> state IDLE, no frame_error. A following full frame with data 1001 is received correctly.
